// File: rtl/exec_unit.sv
// Purpose : multi-cycle 16-bit-instruction execution unit (FETCH/EXEC/MEMWB/HALT) with private imem and dmem.
// Latency : LOAD retires in 3 cycles, every other instruction in 2; HALT is absorbing until reset.
// Backpres: none; the unit free-runs from reset and has no flow-controlled interfaces.
// Ports   : clk (sole clock), reset (synchronous, active-high), halted (high while in HALT).
// Config  : define EXEC_UNIT_MUL_EN to make opcode B a multiply; otherwise opcode B is a NOP.

// Single-port memory with registered read; contents are never reset so preloads survive.
module sync_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] memory [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
        if (en) begin
            rdata <= memory[addr];
        end
    end
endmodule

module exec_unit #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    output logic halted
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEMWB = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [ADDR_BITS-1:0] pc, pc_nx;
    logic [DATA_BITS-1:0] regs [0:15];
    logic                 zf, cf, zf_nx, cf_nx;

    // The imem output register only loads in FETCH, so it doubles as the
    // instruction register and still holds a LOAD during its MEMWB cycle.
    logic [15:0]          instr;
    logic [3:0]           op, rd, ra, rb;
    logic [ADDR_BITS-1:0] addr8;
    logic [DATA_BITS-1:0] imm8;
    logic [DATA_BITS-1:0] a_val, b_val, dmem_rdata;
    logic [DATA_BITS:0]   sum, diff;

    logic                 reg_we;
    logic [DATA_BITS-1:0] reg_wdat;
    logic                 dmem_we;
    logic                 alu_op;
    logic [DATA_BITS-1:0] alu_res;

    assign op    = instr[15:12];
    assign rd    = instr[11:8];
    assign ra    = instr[7:4];
    assign rb    = instr[3:0];
    assign addr8 = ADDR_BITS'(instr[7:0]);
    assign imm8  = DATA_BITS'(instr[7:0]);

    // Operands are read from the pre-edge register file, so rd==ra/rb aliasing
    // naturally reads old values and writes the new one.
    assign a_val = regs[ra];
    assign b_val = regs[rb];
    assign sum   = {1'b0, a_val} + {1'b0, b_val};
    assign diff  = {1'b0, a_val} - {1'b0, b_val};

`ifdef EXEC_UNIT_MUL_EN
    logic [2*DATA_BITS-1:0] prod;
    assign prod = a_val * b_val;
`endif

    sync_ram #(.AW(ADDR_BITS), .DW(16)) imem (
        .clk   (clk),
        .en    (state == FETCH),
        .we    (1'b0),
        .addr  (pc),
        .wdata (16'h0000),
        .rdata (instr)
    );

    // A STORE whose EXEC edge coincides with reset is dropped.
    sync_ram #(.AW(ADDR_BITS), .DW(DATA_BITS)) memory (
        .clk   (clk),
        .en    (1'b1),
        .we    (dmem_we & ~reset),
        .addr  (addr8),
        .wdata (regs[rd]),
        .rdata (dmem_rdata)
    );

    assign halted = (state == HALT);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        zf_nx    = zf;
        cf_nx    = cf;
        reg_we   = 1'b0;
        reg_wdat = '0;
        dmem_we  = 1'b0;
        alu_op   = 1'b0;
        alu_res  = '0;
        case (state)
            FETCH: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                pc_nx    = pc + ADDR_BITS'(1);
                case (op)
                    4'h1: state_nx = MEMWB;
                    4'h2: dmem_we = 1'b1;
                    4'h3: begin
                        reg_we   = 1'b1;
                        reg_wdat = imm8;
                    end
                    4'h4: begin
                        alu_op  = 1'b1;
                        alu_res = sum[DATA_BITS-1:0];
                        cf_nx   = sum[DATA_BITS];
                    end
                    4'h5: begin
                        alu_op  = 1'b1;
                        alu_res = diff[DATA_BITS-1:0];
                        cf_nx   = diff[DATA_BITS];
                    end
                    4'h6: begin
                        alu_op  = 1'b1;
                        alu_res = a_val & b_val;
                        cf_nx   = 1'b0;
                    end
                    4'h7: begin
                        alu_op  = 1'b1;
                        alu_res = a_val | b_val;
                        cf_nx   = 1'b0;
                    end
                    4'h8: begin
                        alu_op  = 1'b1;
                        alu_res = a_val ^ b_val;
                        cf_nx   = 1'b0;
                    end
`ifdef EXEC_UNIT_MUL_EN
                    4'hB: begin
                        alu_op  = 1'b1;
                        alu_res = prod[DATA_BITS-1:0];
                        cf_nx   = (prod[2*DATA_BITS-1:DATA_BITS] != '0);
                    end
`endif
                    4'h9: pc_nx = addr8;
                    4'hA: begin
                        if (zf) begin
                            pc_nx = addr8;
                        end
                    end
                    4'hF: begin
                        pc_nx    = pc;
                        state_nx = HALT;
                    end
                    default: ;
                endcase
                if (alu_op) begin
                    reg_we   = 1'b1;
                    reg_wdat = alu_res;
                    zf_nx    = (alu_res == '0);
                end
            end
            MEMWB: begin
                reg_we   = 1'b1;
                reg_wdat = dmem_rdata;
                state_nx = FETCH;
            end
            HALT: state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            zf    <= zf_nx;
            cf    <= cf_nx;
            if (reg_we) begin
                regs[rd] <= reg_wdat;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Purpose : self-checking bench for exec_unit: directed sequences, an ALU vector table and random programs.
// Latency : checks sample at the falling edge, half a cycle after the state update.
// Backpres: none; every wait is bounded by a cycle budget or the watchdog.
module tb_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halted;

    int checks = 0;
    int failures = 0;

    exec_unit #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .halted (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] prog [256];
    logic [7:0]  m_regs [16];
    logic [7:0]  m_mem [256];
    logic        m_zf, m_cf;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zf;
        logic       cf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int rd, input int ra, input int rb);
        ins = {4'(op), 4'(rd), 4'(ra), 4'(rb)};
    endfunction

    function automatic logic [15:0] insi(input int op, input int rd, input int imm);
        insi = {4'(op), 4'(rd), 8'(imm)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.imem.memory[i] = prog[i];
    endtask

    task automatic preload_dmem();
        for (int i = 0; i < 256; i++) dut.memory.memory[i] = (i < 128) ? 8'(8'h10 + i) : 8'h00;
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < budget) begin
            step(1);
            cyc++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    function automatic int low_mem_errors();
        int bad = 0;
        for (int i = 0; i < 128; i++)
            if (dut.memory.memory[i] !== 8'(8'h10 + i)) bad++;
        return bad;
    endfunction

    // Instruction-level reference: interprets prog[] against m_regs/m_mem and
    // returns the cycle count the program should take up to entering HALT.
    task automatic ref_run(output int cyc);
        int p = 0;
        cyc = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            logic [15:0] w;
            int op, rd, a, b, r;
            w  = prog[p];
            op = int'(w[15:12]);
            rd = int'(w[11:8]);
            a  = int'(m_regs[w[7:4]]);
            b  = int'(m_regs[w[3:0]]);
            r  = -1;
            cyc += (op == 1) ? 3 : 2;
            case (op)
                1: m_regs[rd] = m_mem[w[7:0]];
                2: m_mem[w[7:0]] = m_regs[rd];
                3: m_regs[rd] = w[7:0];
                4: begin r = (a + b) % 256; m_cf = (a + b) > 255; end
                5: begin r = (a - b + 256) % 256; m_cf = a < b; end
                6: begin r = a & b; m_cf = 0; end
                7: begin r = a | b; m_cf = 0; end
                8: begin r = a ^ b; m_cf = 0; end
`ifdef EXEC_UNIT_MUL_EN
                11: begin r = (a * b) % 256; m_cf = (a * b) > 255; end
`endif
                15: return;
                default: ;
            endcase
            if (r >= 0) begin
                m_regs[rd] = 8'(r);
                m_zf = (r == 0);
            end
            p = (p + 1) % 256;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        logic [7:0] pc_hold;
        vec_t vt [14];

        // ---- LOAD latency from reset
        preload_dmem();
        clear_prog();
        prog[0] = insi(1, 1, 5);
        prog[1] = ins(15, 0, 0, 0);
        load_prog();
        apply_reset();
        chk("reset_pc", 32'(dut.pc), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        step(2);
        chk("load_r1_before_memwb", 32'(dut.regs[1]), 32'h00);
        step(1);
        chk("load_r1", 32'(dut.regs[1]), 32'h15);

        // ---- ADD carry, SUB zero, aliased ADD
        clear_prog();
        prog[0] = insi(3, 2, 8'h80);
        prog[1] = insi(3, 3, 8'h90);
        prog[2] = ins(4, 4, 2, 3);
        prog[3] = ins(5, 5, 2, 2);
        prog[4] = ins(4, 2, 2, 2);
        prog[5] = ins(15, 0, 0, 0);
        load_prog();
        apply_reset();
        step(6);
        chk("add_r4", 32'(dut.regs[4]), 32'h10);
        chk("add_cf", 32'(dut.cf), 32'd1);
        chk("add_zf", 32'(dut.zf), 32'd0);
        step(2);
        chk("sub_r5", 32'(dut.regs[5]), 32'h00);
        chk("sub_zf", 32'(dut.zf), 32'd1);
        chk("sub_cf", 32'(dut.cf), 32'd0);
        step(2);
        chk("alias_add_r2", 32'(dut.regs[2]), 32'h00);
        chk("alias_add_cf", 32'(dut.cf), 32'd1);
        step(2);
        chk("halt_after_seq", 32'(halted), 32'd1);

        // ---- reset clears architectural state but not memory
        apply_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) if (dut.regs[i] !== 8'h00) bad++;
        chk("reset_regs_nonzero", 32'(bad), 32'd0);
        chk("reset_zf", 32'(dut.zf), 32'd0);
        chk("reset_cf", 32'(dut.cf), 32'd0);
        chk("reset_pc2", 32'(dut.pc), 32'd0);
        chk("reset_halted2", 32'(halted), 32'd0);
        chk("reset_mem_intact", 32'(low_mem_errors()), 32'd0);

        // ---- STORE then LOAD through high memory
        clear_prog();
        prog[0] = insi(3, 6, 8'hAB);
        prog[1] = insi(2, 6, 200);
        prog[2] = insi(1, 7, 200);
        prog[3] = ins(15, 0, 0, 0);
        load_prog();
        apply_reset();
        run_to_halt(50, cyc);
        chk("st_ld_cycles", 32'(cyc), 32'd9);
        chk("store_mem200", 32'(dut.memory.memory[200]), 32'hAB);
        chk("load_r7", 32'(dut.regs[7]), 32'hAB);
        chk("low_mem_unchanged", 32'(low_mem_errors()), 32'd0);

        // ---- JZ taken / not taken, JMP wrap
        clear_prog();
        prog[0]    = insi(3, 1, 1);
        prog[1]    = insi(3, 2, 1);
        prog[2]    = ins(5, 3, 1, 2);
        prog[3]    = insi(10, 0, 8'h40);
        prog[8'h40] = ins(4, 3, 1, 2);
        prog[8'h41] = insi(10, 0, 8'h10);
        prog[8'h42] = insi(9, 0, 8'hFF);
        prog[8'hFF] = 16'h0000;
        load_prog();
        apply_reset();
        step(8);
        chk("jz_taken_pc", 32'(dut.pc), 32'h40);
        step(4);
        chk("jz_not_taken_pc", 32'(dut.pc), 32'h42);
        step(2);
        chk("jmp_pc", 32'(dut.pc), 32'hFF);
        step(2);
        chk("pc_wrap", 32'(dut.pc), 32'h00);

        // ---- reset during LOAD's MEMWB aborts the write
        preload_dmem();
        clear_prog();
        prog[0] = insi(1, 1, 3);
        load_prog();
        apply_reset();
        step(2);
        apply_reset();
        chk("abort_load_r1", 32'(dut.regs[1]), 32'h00);
        chk("abort_load_pc", 32'(dut.pc), 32'h00);
        chk("abort_load_mem", 32'(low_mem_errors()), 32'd0);

        // ---- reset on a STORE's EXEC edge drops the store
        clear_prog();
        prog[0] = insi(2, 0, 10);
        load_prog();
        apply_reset();
        step(1);
        apply_reset();
        chk("abort_store_mem10", 32'(dut.memory.memory[10]), 32'h1A);

        // ---- HALT is absorbing
        clear_prog();
        prog[0] = ins(15, 0, 0, 0);
        load_prog();
        apply_reset();
        step(2);
        chk("halt_state", 32'(halted), 32'd1);
        pc_hold = dut.pc;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (halted !== 1'b1 || dut.pc !== 8'h00) bad++;
        end
        chk("halt_hold_20", 32'(bad), 32'd0);
        chk("halt_pc", 32'(pc_hold), 32'h00);
        chk("halt_mem_intact", 32'(low_mem_errors()), 32'd0);

        // ---- ALU vector table; prior ADD leaves zf=0, cf=1 so clears and holds are visible
        vt[0]  = '{4'h4, 8'h80, 8'h90, 8'h10, 1'b0, 1'b1};
        vt[1]  = '{4'h4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vt[2]  = '{4'h4, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vt[3]  = '{4'h5, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vt[4]  = '{4'h5, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vt[5]  = '{4'h5, 8'h90, 8'h80, 8'h10, 1'b0, 1'b0};
        vt[6]  = '{4'h6, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vt[7]  = '{4'h6, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vt[8]  = '{4'h7, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vt[9]  = '{4'h7, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
        vt[10] = '{4'h8, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
        vt[11] = '{4'h8, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
`ifdef EXEC_UNIT_MUL_EN
        vt[12] = '{4'hB, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
`else
        vt[12] = '{4'hB, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1};
`endif
        vt[13] = '{4'hC, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            clear_prog();
            prog[0] = insi(3, 1, 8'hFF);
            prog[1] = ins(4, 4, 1, 1);
            prog[2] = insi(3, 1, int'(vt[i].a));
            prog[3] = insi(3, 2, int'(vt[i].b));
            prog[4] = ins(int'(vt[i].op), 3, 1, 2);
            prog[5] = ins(15, 0, 0, 0);
            load_prog();
            apply_reset();
            run_to_halt(100, cyc);
            chk($sformatf("vec%0d_res", i), 32'(dut.regs[3]), 32'(vt[i].res));
            chk($sformatf("vec%0d_zf", i), 32'(dut.zf), 32'(vt[i].zf));
            chk($sformatf("vec%0d_cf", i), 32'(dut.cf), 32'(vt[i].cf));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd12);
        end

        // ---- random programs against the instruction-level model
        for (int t = 0; t < 20; t++) begin
            int exp_cyc;
            clear_prog();
            for (int k = 0; k < 12; k++) begin
                int sel, rd, ra, rb;
                sel = $urandom_range(0, 9);
                rd  = $urandom_range(0, 15);
                ra  = $urandom_range(0, 15);
                rb  = $urandom_range(0, 15);
                case (sel)
                    0, 1: prog[k] = insi(3, rd, $urandom_range(0, 255));
                    2:    prog[k] = insi(2, rd, $urandom_range(128, 255));
                    3:    prog[k] = insi(1, rd, $urandom_range(128, 255));
                    4:    prog[k] = ins($urandom_range(0, 1) ? 0 : $urandom_range(12, 14), rd, ra, rb);
                    default: begin
                        int ops [6] = '{4, 5, 6, 7, 8, 11};
                        prog[k] = ins(ops[$urandom_range(0, 5)], rd, ra, rb);
                    end
                endcase
            end
            prog[12] = ins(15, 0, 0, 0);
            for (int i = 0; i < 256; i++) begin
                m_mem[i] = (i < 128) ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
                dut.memory.memory[i] = m_mem[i];
            end
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_zf = 1'b0;
            m_cf = 1'b0;
            ref_run(exp_cyc);
            load_prog();
            apply_reset();
            step(exp_cyc - 1);
            chk($sformatf("rnd%0d_not_halted_early", t), 32'(halted), 32'd0);
            step(1);
            chk($sformatf("rnd%0d_halted", t), 32'(halted), 32'd1);
            for (int i = 0; i < 16; i++)
                chk($sformatf("rnd%0d_r%0d", t, i), 32'(dut.regs[i]), 32'(m_regs[i]));
            chk($sformatf("rnd%0d_zf", t), 32'(dut.zf), 32'(m_zf));
            chk($sformatf("rnd%0d_cf", t), 32'(dut.cf), 32'(m_cf));
            bad = 0;
            for (int i = 0; i < 256; i++) if (dut.memory.memory[i] !== m_mem[i]) bad++;
            chk($sformatf("rnd%0d_mem", t), 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
